reg_write_arbiter: RTL and testbench

//   Shares the single write port of the 8x8 register file between two writers:

---
 rtl/reg_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Two 1-entry write buffers (A: ALU writeback, B: load writeback) share the
// single register-file write port. A round-robin arbiter drains one buffer per
// cycle into a registered write stage. PENDING shows, for each register, a
// write that is buffered or in the write stage but not yet committed.
module reg_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    A_VALID,
    output logic                    A_READY,
    input  logic [ADDR_W-1:0]       A_ADDR,
    input  logic [DATA_W-1:0]       A_DATA,
    input  logic                    B_VALID,
    output logic                    B_READY,
    input  logic [ADDR_W-1:0]       B_ADDR,
    input  logic [DATA_W-1:0]       B_DATA,
    output logic                    RF_WRITE,
    output logic [ADDR_W-1:0]       RF_INADDRESS,
    output logic [DATA_W-1:0]       RF_IN,
    output logic [(1<<ADDR_W)-1:0]  PENDING
);

    localparam int NREG = 1 << ADDR_W;

    logic              full_a_q, full_a_d;
    logic              full_b_q, full_b_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              prio_q, prio_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic              gnt_a;
    logic              gnt_b;
    logic              acc_a;
    logic              acc_b;

    // Round-robin grant from registered state only; PRIO breaks ties when both buffers hold a write.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (full_a_q && full_b_q) begin
            gnt_a = ~prio_q;
            gnt_b = prio_q;
        end else begin
            gnt_a = full_a_q;
            gnt_b = full_b_q;
        end
    end

    // A buffer being drained this cycle can take a new entry on the same edge.
    assign A_READY = ~full_a_q | gnt_a;
    assign B_READY = ~full_b_q | gnt_b;
    assign acc_a   = A_VALID & A_READY;
    assign acc_b   = B_VALID & B_READY;

    // Next-state for buffers, priority pointer and the write stage.
    always_comb begin
        full_a_d   = full_a_q;
        addr_a_d   = addr_a_q;
        data_a_d   = data_a_q;
        full_b_d   = full_b_q;
        addr_b_d   = addr_b_q;
        data_b_d   = data_b_q;
        prio_d     = prio_q;
        rf_write_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;

        if (acc_a) begin
            full_a_d = 1'b1;
            addr_a_d = A_ADDR;
            data_a_d = A_DATA;
        end else if (gnt_a) begin
            full_a_d = 1'b0;
        end

        if (acc_b) begin
            full_b_d = 1'b1;
            addr_b_d = B_ADDR;
            data_b_d = B_DATA;
        end else if (gnt_b) begin
            full_b_d = 1'b0;
        end

        if (gnt_a) begin
            rf_write_d = 1'b1;
            rf_addr_d  = addr_a_q;
            rf_data_d  = data_a_q;
            prio_d     = 1'b1;
        end else if (gnt_b) begin
            rf_write_d = 1'b1;
            rf_addr_d  = addr_b_q;
            rf_data_d  = data_b_q;
            prio_d     = 1'b0;
        end
    end

    // Control state and write stage; reset drops any in-flight write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            full_a_q   <= 1'b0;
            full_b_q   <= 1'b0;
            prio_q     <= 1'b0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            full_a_q   <= full_a_d;
            full_b_q   <= full_b_d;
            prio_q     <= prio_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    // Buffer payload registers; meaningful only while the matching FULL flag is set.
    always_ff @(posedge CLK) begin
        addr_a_q <= addr_a_d;
        data_a_q <= data_a_d;
        addr_b_q <= addr_b_d;
        data_b_q <= data_b_d;
    end

    assign RF_WRITE     = rf_write_q;
    assign RF_INADDRESS = rf_addr_q;
    assign RF_IN        = rf_data_q;

    // Per-register view of writes not yet committed to the register file.
    always_comb begin
        PENDING = '0;
        for (int k = 0; k < NREG; k++) begin
            PENDING[k] = (full_a_q   && (addr_a_q  == ADDR_W'(k))) ||
                         (full_b_q   && (addr_b_q  == ADDR_W'(k))) ||
                         (rf_write_q && (rf_addr_q == ADDR_W'(k)));
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter, with a behavioural 8x8 register file
// fed by the write port to observe what actually gets committed.
module tb_reg_write_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              CLK;
    logic              RESET;
    logic              A_VALID;
    logic              A_READY;
    logic [ADDR_W-1:0] A_ADDR;
    logic [DATA_W-1:0] A_DATA;
    logic              B_VALID;
    logic              B_READY;
    logic [ADDR_W-1:0] B_ADDR;
    logic [DATA_W-1:0] B_DATA;
    logic              RF_WRITE;
    logic [ADDR_W-1:0] RF_INADDRESS;
    logic [DATA_W-1:0] RF_IN;
    logic [7:0]        PENDING;

    logic [DATA_W-1:0] rf_model [8];

    int compared   = 0;
    int mismatched = 0;

    reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .A_VALID      (A_VALID),
        .A_READY      (A_READY),
        .A_ADDR       (A_ADDR),
        .A_DATA       (A_DATA),
        .B_VALID      (B_VALID),
        .B_READY      (B_READY),
        .B_ADDR       (B_ADDR),
        .B_DATA       (B_DATA),
        .RF_WRITE     (RF_WRITE),
        .RF_INADDRESS (RF_INADDRESS),
        .RF_IN        (RF_IN),
        .PENDING      (PENDING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file being written by the arbiter.
    always @(posedge CLK) begin
        if (RF_WRITE) rf_model[RF_INADDRESS] <= RF_IN;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin : main
        int ia, ib, nw, cyc;
        logic a_acc, b_acc;
        logic [ADDR_W-1:0] exp_addr [8];
        logic [DATA_W-1:0] exp_data [8];

        for (int r = 0; r < 8; r++) rf_model[r] = '0;
        RESET = 1'b1;
        A_VALID = 1'b0; A_ADDR = '0; A_DATA = '0;
        B_VALID = 1'b0; B_ADDR = '0; B_DATA = '0;
        tick();
        tick();
        RESET = 1'b0;
        tick();

        // reset state
        chk("rst_rf_write", RF_WRITE, 0);
        chk("rst_rf_addr", RF_INADDRESS, 0);
        chk("rst_rf_in", RF_IN, 0);
        chk("rst_pending", PENDING, 8'h00);
        chk("rst_a_ready", A_READY, 1);
        chk("rst_b_ready", B_READY, 1);

        // 1: reset mid-run drops an accepted write
        A_VALID = 1'b1; A_ADDR = 3'd2; A_DATA = 8'h11;
        tick();
        A_VALID = 1'b0;
        chk("t1_pending_before", PENDING, 8'h04);
        #2 RESET = 1'b1;
        #1;
        chk("t1_rf_write", RF_WRITE, 0);
        chk("t1_pending", PENDING, 8'h00);
        chk("t1_a_ready", A_READY, 1);
        chk("t1_b_ready", B_READY, 1);
        #1 RESET = 1'b0;
        tick();
        chk("t1_no_write_e1", RF_WRITE, 0);
        tick();
        chk("t1_no_write_e2", RF_WRITE, 0);
        chk("t1_reg2", rf_model[2], 8'h00);

        // 2: single write latency
        A_VALID = 1'b1; A_ADDR = 3'd3; A_DATA = 8'h5A;
        tick();
        A_VALID = 1'b0;
        chk("t2_pending_n", PENDING, 8'h08);
        chk("t2_rf_write_n", RF_WRITE, 0);
        tick();
        chk("t2_rf_write_n1", RF_WRITE, 1);
        chk("t2_rf_addr_n1", RF_INADDRESS, 3);
        chk("t2_rf_in_n1", RF_IN, 8'h5A);
        chk("t2_pending_n1", PENDING, 8'h08);
        tick();
        chk("t2_rf_write_n2", RF_WRITE, 0);
        chk("t2_pending_n2", PENDING, 8'h00);
        chk("t2_reg3", rf_model[3], 8'h5A);
        chk("t2_addr_hold", RF_INADDRESS, 3);
        chk("t2_data_hold", RF_IN, 8'h5A);

        // clear PRIO back to A-preferred
        RESET = 1'b1;
        #2 RESET = 1'b0;
        tick();

        // 3: collision on register 1, A wins first
        A_VALID = 1'b1; A_ADDR = 3'd1; A_DATA = 8'hAA;
        B_VALID = 1'b1; B_ADDR = 3'd1; B_DATA = 8'hBB;
        tick();
        A_VALID = 1'b0; B_VALID = 1'b0;
        chk("t3_a_ready", A_READY, 1);
        chk("t3_b_ready", B_READY, 0);
        chk("t3_pending", PENDING, 8'h02);
        tick();
        chk("t3_first_we", RF_WRITE, 1);
        chk("t3_first_data", RF_IN, 8'hAA);
        tick();
        chk("t3_second_we", RF_WRITE, 1);
        chk("t3_second_data", RF_IN, 8'hBB);
        chk("t3_reg1_mid", rf_model[1], 8'hAA);
        tick();
        chk("t3_idle", RF_WRITE, 0);
        chk("t3_reg1_final", rf_model[1], 8'hBB);

        // 4: saturation, 4 writes per side, expected strict A,B alternation
        for (int i = 0; i < 4; i++) begin
            exp_addr[2*i]   = ADDR_W'(i);
            exp_data[2*i]   = 8'hA0 + DATA_W'(i);
            exp_addr[2*i+1] = ADDR_W'(4 + i);
            exp_data[2*i+1] = 8'hB0 + DATA_W'(i);
        end
        ia = 0; ib = 0; nw = 0;
        A_VALID = 1'b1; A_ADDR = 3'd0; A_DATA = 8'hA0;
        B_VALID = 1'b1; B_ADDR = 3'd4; B_DATA = 8'hB0;
        for (cyc = 0; cyc < 20; cyc++) begin
            a_acc = A_VALID && A_READY;
            b_acc = B_VALID && B_READY;
            tick();
            if (RF_WRITE) begin
                if (nw < 8) begin
                    chk($sformatf("t4_addr%0d", nw), RF_INADDRESS, exp_addr[nw]);
                    chk($sformatf("t4_data%0d", nw), RF_IN, exp_data[nw]);
                end
                nw++;
            end
            if (a_acc) begin
                ia++;
                if (ia < 4) begin
                    A_ADDR = ADDR_W'(ia); A_DATA = 8'hA0 + DATA_W'(ia);
                end else A_VALID = 1'b0;
            end
            if (b_acc) begin
                ib++;
                if (ib < 4) begin
                    B_ADDR = ADDR_W'(4 + ib); B_DATA = 8'hB0 + DATA_W'(ib);
                end else B_VALID = 1'b0;
            end
        end
        chk("t4_write_count", nw, 8);
        chk("t4_pending_end", PENDING, 8'h00);

        // 5: back-pressure on B while A wins
        A_VALID = 1'b1; A_ADDR = 3'd6; A_DATA = 8'h61;
        B_VALID = 1'b1; B_ADDR = 3'd7; B_DATA = 8'h71;
        tick();
        A_VALID = 1'b0;
        B_DATA = 8'h72;
        chk("t5_b_ready_low", B_READY, 0);
        chk("t5_a_ready", A_READY, 1);
        chk("t5_pending", PENDING, 8'hC0);
        tick();
        chk("t5_w1_addr", RF_INADDRESS, 6);
        chk("t5_w1_data", RF_IN, 8'h61);
        chk("t5_b_ready_high", B_READY, 1);
        tick();
        B_VALID = 1'b0;
        chk("t5_w2_we", RF_WRITE, 1);
        chk("t5_w2_addr", RF_INADDRESS, 7);
        chk("t5_w2_data", RF_IN, 8'h71);
        chk("t5_pending_mid", PENDING, 8'h80);
        tick();
        chk("t5_w3_we", RF_WRITE, 1);
        chk("t5_w3_data", RF_IN, 8'h72);
        tick();
        chk("t5_idle", RF_WRITE, 0);
        chk("t5_reg7", rf_model[7], 8'h72);
        chk("t5_reg6", rf_model[6], 8'h61);
        chk("t5_pending_end", PENDING, 8'h00);

        // 6: streaming from A alone
        for (int i = 0; i < 5; i++) begin
            A_VALID = 1'b1; A_ADDR = ADDR_W'(i); A_DATA = 8'hC0 + DATA_W'(i);
            chk($sformatf("t6_a_ready%0d", i), A_READY, 1);
            tick();
            if (i > 0) begin
                chk($sformatf("t6_we%0d", i - 1), RF_WRITE, 1);
                chk($sformatf("t6_addr%0d", i - 1), RF_INADDRESS, i - 1);
            end
        end
        A_VALID = 1'b0;
        tick();
        chk("t6_we4", RF_WRITE, 1);
        chk("t6_addr4", RF_INADDRESS, 4);
        chk("t6_data4", RF_IN, 8'hC4);
        tick();
        chk("t6_idle", RF_WRITE, 0);
        chk("t6_reg4", rf_model[4], 8'hC4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
